// File: rtl/dmem_responder.sv
// dmem_responder: responder side of the data-memory request interface.
// Accepts one load/store at a time, waits LATENCY cycles, performs the
// byte-lane access on the edge that enters RESP and holds the response
// until the requester takes it.
module dmem_responder #(
   parameter int unsigned ADDR_W  = 11,
   parameter int unsigned LATENCY = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic              req_read,
   input  logic [3:0]        req_writeb,
   input  logic [31:0]       req_wdata,
   output logic              rsp_valid,
   input  logic              rsp_ready,
   output logic [31:0]       rsp_rdata,
   output logic              rsp_err
);

   localparam int unsigned DEPTH    = 2**ADDR_W;
   localparam logic [3:0]  LAT_CNT  = 4'(LATENCY);
   localparam bit          ZERO_LAT = (LATENCY == 0);

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } state_t;

   state_t              r_state;
   logic [3:0]          r_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic                r_read;
   logic [3:0]          r_writeb;
   logic [31:0]         r_wdata;
   logic                r_req_ready;
   logic                r_rsp_valid;
   logic [31:0]         r_rdata;
   logic                r_err;
   logic [31:0]         r_mem [DEPTH];

   logic                w_accept;
   logic                w_access;
   logic [ADDR_W-1:0]   w_addr;
   logic                w_read;
   logic [3:0]          w_writeb;
   logic [31:0]         w_wdata;
   logic [31:0]         w_rword;
   logic                w_null;

   // Select the request fields used at the access edge: with zero wait
   // states the access happens on the accept edge itself, so the live
   // request is used; otherwise the captured copy is used.
   always_comb begin
      w_accept = r_req_ready && req_valid;
      w_access = rst_n && ((ZERO_LAT && w_accept) ||
                           ((r_state == WAIT) && (r_cnt == 4'd1)));
      if (r_state == IDLE) begin
         w_addr   = req_addr;
         w_read   = req_read;
         w_writeb = req_writeb;
         w_wdata  = req_wdata;
      end else begin
         w_addr   = r_addr;
         w_read   = r_read;
         w_writeb = r_writeb;
         w_wdata  = r_wdata;
      end
      w_rword = r_mem[w_addr];
      w_null  = !w_read && (w_writeb == '0);
   end

   // Byte-lane write into the word array on the access edge (array is not reset).
   always_ff @(posedge clk) begin
      for (int unsigned i = 0; i < 4; i++) begin
         if (w_access && w_writeb[i]) begin
            r_mem[w_addr][8*i +: 8] <= w_wdata[8*i +: 8];
         end
      end
   end

   // Request/response FSM with registered handshake outputs and response data.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_addr      <= '0;
         r_read      <= 1'b0;
         r_writeb    <= '0;
         r_wdata     <= '0;
         r_req_ready <= 1'b1;
         r_rsp_valid <= 1'b0;
         r_rdata     <= '0;
         r_err       <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_addr      <= req_addr;
                  r_read      <= req_read;
                  r_writeb    <= req_writeb;
                  r_wdata     <= req_wdata;
                  r_req_ready <= 1'b0;
                  if (ZERO_LAT) begin
                     r_state     <= RESP;
                     r_rsp_valid <= 1'b1;
                     r_rdata     <= w_read ? w_rword : '0;
                     r_err       <= w_null;
                  end else begin
                     r_cnt   <= LAT_CNT;
                     r_state <= WAIT;
                  end
               end
            end
            WAIT: begin
               r_cnt <= r_cnt - 4'd1;
               if (r_cnt == 4'd1) begin
                  r_state     <= RESP;
                  r_rsp_valid <= 1'b1;
                  // w_rword is the word before this edge's write: read-before-write
                  r_rdata     <= w_read ? w_rword : '0;
                  r_err       <= w_null;
               end
            end
            RESP: begin
               if (rsp_ready) begin
                  r_state     <= IDLE;
                  r_rsp_valid <= 1'b0;
                  r_req_ready <= 1'b1;
               end
            end
            default: begin
               r_state     <= IDLE;
               r_rsp_valid <= 1'b0;
               r_req_ready <= 1'b1;
            end
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign rsp_valid = r_rsp_valid;
   assign rsp_rdata = r_rdata;
   assign rsp_err   = r_err;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: three instances (LATENCY 1, 0, 4), each with
// directed transactions, randomized traffic and a transaction-level model.
`timescale 1ns/1ps
module tb_dmem_responder;

   localparam int unsigned AW = 11;
   localparam int          NI = 3;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   int unsigned n_chk = 0;
   int unsigned n_err = 0;
   bit          done [NI];

   task automatic chk(input int inst, input string name, input logic [31:0] got,
                      input logic [31:0] exp, input logic [31:0] mask);
      n_chk++;
      if (((got ^ exp) & mask) !== 32'd0) begin
         n_err++;
         $display("FAIL inst%0d %s: got %08h expected %08h (mask %08h) t=%0t",
                  inst, name, got, exp, mask, $time);
      end
   endtask

   for (genvar k = 0; k < NI; k++) begin : g_inst
      localparam int unsigned LAT = (k == 0) ? 1 : ((k == 1) ? 0 : 4);

      logic          rst_n;
      logic          req_valid, req_ready, req_read;
      logic [AW-1:0] req_addr;
      logic [3:0]    req_writeb;
      logic [31:0]   req_wdata;
      logic          rsp_valid, rsp_ready, rsp_err;
      logic [31:0]   rsp_rdata;

      dmem_responder #(.ADDR_W(AW), .LATENCY(LAT)) u_dut (
         .clk        (clk),
         .rst_n      (rst_n),
         .req_valid  (req_valid),
         .req_ready  (req_ready),
         .req_addr   (req_addr),
         .req_read   (req_read),
         .req_writeb (req_writeb),
         .req_wdata  (req_wdata),
         .rsp_valid  (rsp_valid),
         .rsp_ready  (rsp_ready),
         .rsp_rdata  (rsp_rdata),
         .rsp_err    (rsp_err)
      );

      // ---------------- reference model ----------------
      logic [31:0]   mm [2**AW];   // word contents
      logic [3:0]    mk [2**AW];   // which bytes are known
      logic          m_pend, m_resp, c_read, e_err;
      int unsigned   m_left;
      logic [AW-1:0] c_addr;
      logic [3:0]    c_wb;
      logic [31:0]   c_wd, e_rdata, e_mask;

      task automatic m_commit();
         logic [31:0] wmask, kmask;
         wmask = {{8{c_wb[3]}}, {8{c_wb[2]}}, {8{c_wb[1]}}, {8{c_wb[0]}}};
         kmask = {{8{mk[c_addr][3]}}, {8{mk[c_addr][2]}}, {8{mk[c_addr][1]}}, {8{mk[c_addr][0]}}};
         e_err = !c_read && (c_wb == 4'd0);
         if (c_read) begin
            e_rdata = mm[c_addr];
            e_mask  = kmask;
         end else begin
            e_rdata = 32'd0;
            e_mask  = 32'hFFFF_FFFF;
         end
         mm[c_addr] = (mm[c_addr] & ~wmask) | (c_wd & wmask);
         mk[c_addr] = mk[c_addr] | c_wb;
         m_resp = 1'b1;
      endtask

      initial begin : model
         m_pend = 1'b0; m_resp = 1'b0; m_left = 0;
         c_addr = '0; c_read = 1'b0; c_wb = '0; c_wd = '0;
         e_rdata = '0; e_mask = '0; e_err = 1'b0;
         for (int i = 0; i < 2**AW; i++) mk[i] = 4'd0;
         forever begin
            @(negedge clk);
            if (!rst_n) begin
               m_pend = 1'b0;
               m_resp = 1'b0;
            end
            chk(k, "req_ready", 32'(req_ready), 32'(!m_pend), 32'd1);
            chk(k, "rsp_valid", 32'(rsp_valid), 32'(m_resp), 32'd1);
            if (!rst_n) begin
               chk(k, "rsp_rdata in reset", rsp_rdata, 32'd0, 32'hFFFF_FFFF);
               chk(k, "rsp_err in reset", 32'(rsp_err), 32'd0, 32'd1);
            end else if (m_resp) begin
               if (e_mask != 32'd0) chk(k, "rsp_rdata", rsp_rdata, e_rdata, e_mask);
               chk(k, "rsp_err", 32'(rsp_err), 32'(e_err), 32'd1);
            end
            // predict the coming rising edge from the inputs presented now
            if (rst_n) begin
               if (!m_pend) begin
                  if (req_valid) begin
                     m_pend = 1'b1;
                     c_addr = req_addr; c_read = req_read;
                     c_wb = req_writeb; c_wd = req_wdata;
                     m_left = LAT;
                     if (m_left == 0) m_commit();
                  end
               end else if (!m_resp) begin
                  m_left--;
                  if (m_left == 0) m_commit();
               end else if (rsp_ready) begin
                  m_pend = 1'b0;
                  m_resp = 1'b0;
               end
            end
         end
      end

      // ---------------- driver ----------------
      task automatic do_req(input logic [AW-1:0] a, input logic rd, input logic [3:0] wb,
                            input logic [31:0] wd, input int unsigned hold,
                            output logic [31:0] rdata, output logic err, output int unsigned lat);
         logic acc;
         int unsigned n;
         req_valid = 1'b1; req_addr = a; req_read = rd; req_writeb = wb; req_wdata = wd;
         rsp_ready = 1'b0;
         acc = 1'b0; n = 0;
         while (!acc && n < 50) begin
            acc = req_ready;
            @(posedge clk); #1;
            n++;
         end
         if (!acc) chk(k, "accept wait", 32'(acc), 32'd1, 32'd1);
         req_valid  = 1'b0;
         req_addr   = 11'($urandom_range(0, 2047));
         req_read   = 1'($urandom_range(0, 1));
         req_writeb = 4'($urandom_range(0, 15));
         req_wdata  = $urandom;
         lat = 0;
         while (!rsp_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
         end
         if (!rsp_valid) chk(k, "rsp_valid wait", 32'(rsp_valid), 32'd1, 32'd1);
         rdata = rsp_rdata;
         err   = rsp_err;
         for (int unsigned h = 0; h < hold; h++) begin
            req_valid  = 1'b1;
            req_addr   = 11'($urandom_range(0, 31));
            req_writeb = 4'hF;
            @(posedge clk); #1;
         end
         req_valid = 1'b0;
         rsp_ready = 1'b1;
         @(posedge clk); #1;
         rsp_ready = 1'b0;
      endtask

      initial begin : drive
         logic [31:0] rd;
         logic        er, acc;
         int unsigned lt, n;
         rst_n = 1'b0; req_valid = 1'b0; req_addr = '0; req_read = 1'b0;
         req_writeb = '0; req_wdata = '0; rsp_ready = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         chk(k, "reset req_ready", 32'(req_ready), 32'd1, 32'd1);
         chk(k, "reset rsp_valid", 32'(rsp_valid), 32'd0, 32'd1);
         chk(k, "reset rsp_rdata", rsp_rdata, 32'd0, 32'hFFFF_FFFF);
         chk(k, "reset rsp_err", 32'(rsp_err), 32'd0, 32'd1);
         rst_n = 1'b1;
         @(posedge clk); #1;

         // full-word write then read
         do_req(11'h010, 1'b0, 4'hF, 32'hDEADBEEF, 0, rd, er, lt);
         chk(k, "write latency", lt, LAT, 32'hFFFF_FFFF);
         chk(k, "write ack rdata", rd, 32'd0, 32'hFFFF_FFFF);
         chk(k, "write ack err", 32'(er), 32'd0, 32'd1);
         do_req(11'h010, 1'b1, 4'h0, 32'h0, 0, rd, er, lt);
         chk(k, "read latency", lt, LAT, 32'hFFFF_FFFF);
         chk(k, "read DEADBEEF", rd, 32'hDEADBEEF, 32'hFFFF_FFFF);
         chk(k, "read err", 32'(er), 32'd0, 32'd1);

         // byte and halfword lanes
         do_req(11'd5, 1'b0, 4'hF, 32'h11223344, 0, rd, er, lt);
         do_req(11'd5, 1'b0, 4'b0100, 32'h00AA0000, 0, rd, er, lt);
         do_req(11'd5, 1'b1, 4'h0, 32'h0, 0, rd, er, lt);
         chk(k, "byte lane", rd, 32'h11AA3344, 32'hFFFF_FFFF);
         do_req(11'd5, 1'b0, 4'b1100, 32'hBEEF0000, 0, rd, er, lt);
         do_req(11'd5, 1'b1, 4'h0, 32'h0, 0, rd, er, lt);
         chk(k, "halfword lane", rd, 32'hBEEF3344, 32'hFFFF_FFFF);

         // read-before-write
         do_req(11'd7, 1'b0, 4'hF, 32'h00000000, 0, rd, er, lt);
         do_req(11'd7, 1'b1, 4'hF, 32'h12345678, 0, rd, er, lt);
         chk(k, "read-before-write old", rd, 32'h00000000, 32'hFFFF_FFFF);
         do_req(11'd7, 1'b1, 4'h0, 32'h0, 0, rd, er, lt);
         chk(k, "read-before-write new", rd, 32'h12345678, 32'hFFFF_FFFF);

         // backpressure with an ignored request pending
         do_req(11'h010, 1'b1, 4'h0, 32'h0, 5, rd, er, lt);
         chk(k, "backpressure rdata", rd, 32'hDEADBEEF, 32'hFFFF_FFFF);

         // null request
         do_req(11'd5, 1'b0, 4'h0, 32'hFFFF_FFFF, 0, rd, er, lt);
         chk(k, "null err", 32'(er), 32'd1, 32'd1);
         chk(k, "null rdata", rd, 32'd0, 32'hFFFF_FFFF);
         chk(k, "null latency", lt, LAT, 32'hFFFF_FFFF);
         do_req(11'd5, 1'b1, 4'h0, 32'h0, 0, rd, er, lt);
         chk(k, "null leaves array", rd, 32'hBEEF3344, 32'hFFFF_FFFF);

         // reset two cycles after accepting a write
         do_req(11'd9, 1'b0, 4'hF, 32'hCAFEF00D, 0, rd, er, lt);
         req_valid = 1'b1; req_addr = 11'd9; req_read = 1'b0;
         req_writeb = 4'hF; req_wdata = 32'h55555555; rsp_ready = 1'b0;
         acc = 1'b0; n = 0;
         while (!acc && n < 50) begin
            acc = req_ready;
            @(posedge clk); #1;
            n++;
         end
         req_valid = 1'b0;
         chk(k, "reset-test accept", 32'(acc), 32'd1, 32'd1);
         repeat (2) @(posedge clk);
         #1;
         rst_n = 1'b0;
         #1;
         chk(k, "async reset req_ready", 32'(req_ready), 32'd1, 32'd1);
         chk(k, "async reset rsp_valid", 32'(rsp_valid), 32'd0, 32'd1);
         @(posedge clk); #1;
         rst_n = 1'b1;
         do_req(11'd9, 1'b1, 4'h0, 32'h0, 0, rd, er, lt);
         chk(k, "write across reset", rd, (LAT > 2) ? 32'hCAFEF00D : 32'h55555555,
             32'hFFFF_FFFF);

         // randomized traffic, backpressure and occasional resets
         for (int c = 0; c < 600; c++) begin
            req_valid  = ($urandom_range(0, 2) != 0);
            req_addr   = 11'($urandom_range(0, 31));
            req_read   = 1'($urandom_range(0, 1));
            req_writeb = 4'($urandom_range(0, 15));
            req_wdata  = $urandom;
            rsp_ready  = ($urandom_range(0, 3) != 0);
            rst_n      = ($urandom_range(0, 99) != 0);
            @(posedge clk); #1;
         end
         rst_n = 1'b1; req_valid = 1'b0; rsp_ready = 1'b1;
         repeat (LAT + 4) @(posedge clk);
         #1;
         done[k] = 1'b1;
      end
   end

   initial begin : finisher
      int unsigned cyc;
      cyc = 0;
      while (!(done[0] && done[1] && done[2]) && cyc < 20000) begin
         @(posedge clk);
         cyc++;
      end
      if (!(done[0] && done[1] && done[2])) begin
         n_chk++;
         n_err++;
         $display("FAIL completion: drivers not done after %0d cycles, required all done", cyc);
      end
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
